// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Sequential front-end for the 16-bit combinational ALU. One operation at a
// time is accepted over a valid/ready handshake. The opcode and operands are
// registered and held on the ALU inputs for SETTLE_CYCLES cycles. The ALU
// result is then captured, trimmed to the width that is meaningful for the
// opcode, and offered downstream with status flags over a second handshake.
//
// Parameters
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   upstream handshake; in_op/in_a/in_b carry the operation
//   alu_s/a/b        registered opcode and operands driven into the ALU
//   alu_z            32-bit ALU result
//   out_valid/ready  downstream handshake
//   out_z            captured, width-cleaned result
//   out_zero/neg     out_z == 0 / out_z[31]
//   out_err          divide by zero (opcode 3 with B == 0)
//   op_count         completed operations (handshakes), wraps at 16 bits
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,

    output logic [3:0]  alu_s,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [31:0] alu_z,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic        out_zero,
    output logic        out_neg,
    output logic        out_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes whose results need width cleaning.
    localparam logic [3:0] OP_ADD = 4'd0;   // 17-bit sum (carry kept)
    localparam logic [3:0] OP_DIV = 4'd3;   // 16-bit quotient
    localparam logic [3:0] OP_6   = 4'd6;   // 16-bit result
    localparam logic [3:0] OP_7   = 4'd7;   // 16-bit result

    localparam logic [3:0]  SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] DIV0_RESULT  = 32'h0000_FFFF;

    // The ALU leaves unspecified bits above the meaningful result width for
    // some opcodes; they are forced to zero before the flags are derived.
    function automatic logic [31:0] clean_result(input logic [3:0]  op,
                                                 input logic [31:0] z);
        logic [31:0] r;
        case (op)
            OP_ADD:             r = {15'b0, z[16:0]};
            OP_DIV, OP_6, OP_7: r = {16'b0, z[15:0]};
            default:            r = z;
        endcase
        return r;
    endfunction

    state_e      state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic        div0_q,   div0_d;
    logic [3:0]  alu_s_q,  alu_s_d;
    logic [15:0] alu_a_q,  alu_a_d;
    logic [15:0] alu_b_q,  alu_b_d;
    logic [31:0] z_q,      z_d;
    logic        zero_q,   zero_d;
    logic        neg_q,    neg_d;
    logic        err_q,    err_d;
    logic [15:0] count_q,  count_d;

    logic [31:0] clean_z;
    logic        in_div0;

    assign clean_z = clean_result(alu_s_q, alu_z);
    assign in_div0 = (in_op == OP_DIV) && (in_b == 16'd0);

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable driven here gets a default first so that no
        // path through the case statement leaves one unassigned (latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        alu_s_d = alu_s_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        z_d     = z_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        err_d   = err_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_s_d = in_op;
                    alu_a_d = in_a;
                    alu_b_d = in_b;
                    div0_d  = in_div0;
                    // Divide by zero does not wait for the ALU: a zero count
                    // makes it complete one cycle after the accept.
                    cnt_d   = in_div0 ? 4'd0 : SETTLE_LOAD;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    if (div0_q) begin
                        z_d    = DIV0_RESULT;
                        zero_d = 1'b0;
                        neg_d  = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        z_d    = clean_z;
                        zero_d = (clean_z == 32'd0);
                        neg_d  = clean_z[31];
                        err_d  = 1'b0;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                // out_valid is high throughout DONE, so out_ready alone
                // completes the handshake.
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            div0_q  <= 1'b0;
            alu_s_q <= 4'd0;
            alu_a_q <= 16'd0;
            alu_b_q <= 16'd0;
            z_q     <= 32'd0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
            alu_s_q <= alu_s_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gated with rst_n so upstream never sees ready while reset is held.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    assign alu_s     = alu_s_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;

    assign out_z     = z_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
    assign out_err   = err_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for alu_op_sequencer (SETTLE_CYCLES = 2). A small model
// of the combinational ALU drives alu_z from the registered ALU inputs; it
// deliberately fills unspecified upper bits with junk so width cleaning is
// observable. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int unsigned SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  alu_s;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [31:0] alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_zero;
    logic        out_neg;
    logic        out_err;
    logic [15:0] op_count;

    logic        garb_en;
    logic [31:0] garb;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_count;

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_z     (alu_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_err   (out_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simplified ALU: only the opcodes exercised here are modelled exactly.
    function automatic logic [31:0] alu_model(input logic [3:0]  s,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [16:0]        sum;
        logic [31:0]        r;
        sa  = {{16{a[15]}}, a};
        sb  = {{16{b[15]}}, b};
        sum = {1'b0, a} + {1'b0, b};
        case (s)
            4'd0:       r = {15'h2AAA, sum};
            4'd1:       r = sa - sb;
            4'd2:       r = sa * sb;
            4'd3:       r = (b == 16'd0) ? 32'hBAD0_0000 : {16'hC3C3, a / b};
            4'd6, 4'd7: r = {16'hA5A5, a ^ b};
            4'd8:       r = {16'h0000, a & b};
            4'd15:      r = (sa < sb) ? 32'd1 : 32'd0;
            default:    r = {a, b};
        endcase
        return r;
    endfunction

    always_comb alu_z = garb_en ? garb : alu_model(alu_s, alu_a, alu_b);

    // One complete operation: accept, measure latency, check the result and,
    // when consume is set, the handshake that follows. Starts and ends on a
    // falling edge.
    task automatic do_op(input string       name,
                         input logic [3:0]  op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input int          exp_lat,
                         input logic [31:0] exp_z,
                         input logic        exp_zero,
                         input logic        exp_neg,
                         input logic        exp_err,
                         input bit          consume);
        int lat;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
        end
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if ({alu_s, alu_a, alu_b} !== {op, a, b}) begin
            n_err++;
            $display("FAIL %s alu inputs: got %h/%h/%h expected %h/%h/%h",
                     name, alu_s, alu_a, alu_b, op, a, b);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_vec++;
        if ({out_z, out_zero, out_neg, out_err} !== {exp_z, exp_zero, exp_neg, exp_err}) begin
            n_err++;
            $display("FAIL %s result: got z=%h zero=%b neg=%b err=%b expected z=%h zero=%b neg=%b err=%b",
                     name, out_z, out_zero, out_neg, out_err, exp_z, exp_zero, exp_neg, exp_err);
        end
        if (consume) begin
            @(negedge clk);
            exp_count = exp_count + 16'd1;
            n_vec++;
            if ({out_valid, op_count} !== {1'b0, exp_count}) begin
                n_err++;
                $display("FAIL %s handshake: got valid=%b count=%h expected valid=0 count=%h",
                         name, out_valid, op_count, exp_count);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_z, out_zero, out_neg, out_err, op_count, alu_s, alu_a, alu_b} !== '0) begin
            n_err++;
            $display("FAIL reset_held: got ready=%b valid=%b z=%h count=%h alu=%h/%h/%h expected all zero",
                     in_ready, out_valid, out_z, op_count, alu_s, alu_a, alu_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_z, op_count} !== {1'b1, 1'b0, 32'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b valid=%b z=%h count=%h expected ready=1 rest zero",
                     in_ready, out_valid, out_z, op_count);
        end
        // out_ready with nothing to deliver must not count anything.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({out_valid, op_count} !== {1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL idle_out_ready: got valid=%b count=%h expected 0/0000", out_valid, op_count);
        end
        exp_count = 16'd0;
    endtask

    task automatic test_add_carry();
        do_op("add_carry", 4'd0, 16'hFFFF, 16'h0001, SETTLE, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_mul_sub();
        do_op("mul_neg", 4'd2, 16'hFFFD, 16'h0005, SETTLE, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op("sub_zero", 4'd1, 16'h0005, 16'h0005, SETTLE, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_div();
        do_op("div_zero", 4'd3, 16'd100, 16'd0, 1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op("div_ok", 4'd3, 16'd100, 16'd7, SETTLE, 32'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_widths();
        do_op("op6_clean", 4'd6, 16'h1234, 16'h00FF, SETTLE, 32'h0000_12CB, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("op7_clean", 4'd7, 16'h8000, 16'h0001, SETTLE, 32'h0000_8001, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("lt_full", 4'd15, 16'hFFFF, 16'h0001, SETTLE, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_op("bp_result", 4'd8, 16'hF0F0, 16'hFF00, SETTLE, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_op    = 4'd3;
            in_a     = 16'h1111;
            in_b     = 16'h0000;
            garb_en  = 1'b1;
            garb     = 32'hDEAD_0000 | 32'(i);
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, out_z, out_zero, out_neg, out_err, op_count, alu_s, alu_a, alu_b}
                !== {1'b1, 1'b0, 32'h0000_F000, 3'b000, exp_count, 4'd8, 16'hF0F0, 16'hFF00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b z=%h flags=%b%b%b count=%h alu=%h/%h/%h expected held result",
                         i, out_valid, in_ready, out_z, out_zero, out_neg, out_err, op_count, alu_s, alu_a, alu_b);
            end
        end
        in_valid  = 1'b0;
        garb_en   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        n_vec++;
        if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, exp_count}) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b count=%h expected 0/1/%h",
                     out_valid, in_ready, op_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_exec();
        in_op    = 4'd2;
        in_a     = 16'd3;
        in_b     = 16'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, out_z, out_zero, out_neg, out_err, op_count, alu_s, alu_a, alu_b} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_clear: got ready=%b valid=%b z=%h count=%h alu=%h/%h/%h expected all zero",
                     in_ready, out_valid, out_z, op_count, alu_s, alu_a, alu_b);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, 16'd0}) begin
                n_err++;
                $display("FAIL mid_reset_idle[%0d]: got valid=%b ready=%b count=%h expected 0/1/0000",
                         i, out_valid, in_ready, op_count);
            end
        end
        do_op("after_reset", 4'd1, 16'd9, 16'd4, SETTLE, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last_acc;
        int n_acc;
        int bad_spacing;
        int bad_z;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 16'd0;
        @(negedge clk);
        in_op       = 4'd0;
        in_a        = 16'd1;
        in_b        = 16'd2;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        cyc         = 0;
        last_acc    = -1;
        n_acc       = 0;
        bad_spacing = 0;
        bad_z       = 0;
        while (n_acc < 65537 && cyc < 65537 * 4 + 64) begin
            if (out_valid === 1'b1 && out_z !== 32'd3) bad_z++;
            if (in_ready === 1'b1) begin
                if (last_acc >= 0 && (cyc - last_acc) != int'(SETTLE + 2)) begin
                    if (bad_spacing == 0)
                        $display("FAIL b2b_spacing first: got %0d expected %0d", cyc - last_acc, SETTLE + 2);
                    bad_spacing++;
                end
                if (n_acc == 65535) begin
                    n_vec++;
                    if (op_count !== 16'hFFFF) begin
                        n_err++;
                        $display("FAIL b2b_count_max: got %h expected FFFF", op_count);
                    end
                end
                if (n_acc == 65536) begin
                    n_vec++;
                    if (op_count !== 16'h0000) begin
                        n_err++;
                        $display("FAIL b2b_count_wrap: got %h expected 0000", op_count);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        repeat (SETTLE + 1) @(negedge clk);
        n_vec++;
        if (n_acc != 65537) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d accepts expected 65537", n_acc);
        end
        n_vec++;
        if (bad_spacing != 0) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad_spacing);
        end
        n_vec++;
        if (bad_z != 0) begin
            n_err++;
            $display("FAIL b2b_result: got %0d bad results expected 0", bad_z);
        end
        n_vec++;
        if ({out_valid, op_count} !== {1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL b2b_final_count: got valid=%b count=%h expected 0/0001", out_valid, op_count);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_count = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        out_ready = 1'b0;
        garb_en   = 1'b0;
        garb      = 32'd0;

        test_reset();
        test_add_carry();
        test_mul_sub();
        test_div();
        test_widths();
        test_backpressure();
        test_reset_mid_exec();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
